// File: rtl/uart_tx_framed.sv
// UART transmitter with a small word FIFO in front of the serialiser.
// Frame: start bit, DATA_BITS payload bits LSB first, optional parity bit,
// then STOP_BITS stop bits. Queued words go out back-to-back.
module uart_tx_framed #(
   parameter int CLK_HZ     = 25_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 9,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        send,
   input  logic [DATA_BITS-1:0]        data,
   output logic                        tx,
   output logic                        ready,
   output logic                        busy,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int DIV = CLK_HZ / BAUD_RATE;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FW  = $clog2(FIFO_DEPTH) + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   localparam logic [CW-1:0] BIT_LAST   = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_BITS - 1);
   localparam logic          STOP_LAST  = (STOP_BITS == 2);
   localparam logic [FW-1:0] FULL_COUNT = FW'(FIFO_DEPTH);

   // Serialiser state
   logic [2:0]           state_reg;
   logic [CW-1:0]        cnt_reg;
   logic [IW-1:0]        idx_reg;
   logic                 stop_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 parity_reg;
   logic                 tx_reg;

   // FIFO state
   logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_reg;
   logic [PW-1:0]        rd_ptr_reg;
   logic [FW-1:0]        count_reg;
   logic [FW-1:0]        count_next;
   logic                 overflow_reg;

   logic                 fifo_empty;
   logic                 push;
   logic                 pop;
   logic                 bit_end;
   logic                 stop_end;
   logic [DATA_BITS-1:0] head;
   logic                 head_parity;

   // Full/empty come from the registered count only, so a pop on the same
   // edge never opens room for a push into a full FIFO.
   assign fifo_empty = (count_reg == '0);
   assign ready      = (count_reg < FULL_COUNT);
   assign push       = send & ready;
   assign bit_end    = (cnt_reg == BIT_LAST);
   assign stop_end   = bit_end & (stop_reg == STOP_LAST);
   assign pop        = ~fifo_empty &
                       ((state_reg == S_IDLE) | ((state_reg == S_STOP) & stop_end));
   assign head        = fifo_mem[rd_ptr_reg];
   assign head_parity = (PARITY == 2) ? ~(^head) : ^head;

   assign tx         = tx_reg;
   assign busy       = (state_reg != S_IDLE) | ~fifo_empty;
   assign overflow   = overflow_reg;
   assign fifo_count = count_reg;

   // Occupancy update: push and pop on the same edge cancel out
   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + FW'(1);
         2'b01:   count_next = count_reg - FW'(1);
         default: count_next = count_reg;
      endcase
   end

   // Word storage; contents need no reset because the count gates every read
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= data;
      end
   end

   // FIFO pointers, occupancy and the one-cycle overflow flag
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         count_reg    <= count_next;
         overflow_reg <= send & ~ready;
      end
   end

   // Frame sequencer: tx is registered and changes on the edge a phase begins
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         idx_reg    <= '0;
         stop_reg   <= 1'b0;
         shift_reg  <= '0;
         parity_reg <= 1'b0;
         tx_reg     <= 1'b1;
      end else begin
         case (state_reg)
            S_IDLE: begin
               cnt_reg <= '0;
               tx_reg  <= 1'b1;
               if (pop) begin
                  shift_reg  <= head;
                  parity_reg <= head_parity;
                  idx_reg    <= '0;
                  state_reg  <= S_START;
                  tx_reg     <= 1'b0;
               end
            end
            S_START: begin
               if (bit_end) begin
                  cnt_reg   <= '0;
                  idx_reg   <= '0;
                  state_reg <= S_DATA;
                  tx_reg    <= shift_reg[0];
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  cnt_reg   <= '0;
                  shift_reg <= shift_reg >> 1;
                  if (idx_reg == IDX_LAST) begin
                     idx_reg <= '0;
                     if (PARITY != 0) begin
                        state_reg <= S_PARITY;
                        tx_reg    <= parity_reg;
                     end else begin
                        state_reg <= S_STOP;
                        stop_reg  <= 1'b0;
                        tx_reg    <= 1'b1;
                     end
                  end else begin
                     idx_reg <= idx_reg + IW'(1);
                     tx_reg  <= shift_reg[1];
                  end
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            S_PARITY: begin
               if (bit_end) begin
                  cnt_reg   <= '0;
                  stop_reg  <= 1'b0;
                  state_reg <= S_STOP;
                  tx_reg    <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  cnt_reg <= '0;
                  if (stop_end) begin
                     stop_reg <= 1'b0;
                     if (pop) begin
                        // Next word starts immediately, no idle gap
                        shift_reg  <= head;
                        parity_reg <= head_parity;
                        idx_reg    <= '0;
                        state_reg  <= S_START;
                        tx_reg     <= 1'b0;
                     end else begin
                        state_reg <= S_IDLE;
                        tx_reg    <= 1'b1;
                     end
                  end else begin
                     stop_reg <= stop_reg + 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            default: begin
               state_reg <= S_IDLE;
               cnt_reg   <= '0;
               tx_reg    <= 1'b1;
            end
         endcase
      end
   end

endmodule
